// File: rtl/f_issue_pkg.sv
// rtl/f_issue_pkg.sv - shared types and helpers for the issue sequencer
package f_issue_pkg;

    localparam int FLEN = 64;

    typedef struct packed {
        logic            err;
        logic [FLEN-1:0] data;
    } res_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so the FIFO depth need not be a power of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/f_res_fifo.sv
// rtl/f_res_fifo.sv - in-order result FIFO, no write-to-read bypass
module f_res_fifo
    import f_issue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = occ_width(DEPTH),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  res_entry_t    push_data,
    input  logic          pop,
    output res_entry_t    pop_data,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          overflow
);

    res_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign overflow = push & full;
    assign do_push  = push & ~full;
    assign do_pop   = pop & (cnt != '0);
    // Head reads as zero while empty so the result bus is clean after reset.
    assign pop_data = (cnt != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (do_pop) begin
                rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/f_issue_seq.sv
// rtl/f_issue_seq.sv - credit-gated issue sequencer for a non-stallable FU
module f_issue_seq
    import f_issue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = occ_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_vld,
    output logic            arg_rdy,
    input  logic [FLEN-1:0] arg_a,
    input  logic [FLEN-1:0] arg_b,
    output logic            fu_up_valid,
    output logic [FLEN-1:0] fu_a,
    output logic [FLEN-1:0] fu_b,
    input  logic [FLEN-1:0] fu_res,
    input  logic            fu_down_valid,
    input  logic            fu_busy,
    input  logic            fu_error,
    output logic            res_vld,
    input  logic            res_rdy,
    output logic [FLEN-1:0] res_data,
    output logic            res_err,
    output logic [CW-1:0]   inflight,
    output logic            proto_err
);

    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occ;
    logic          credit_ok;
    logic          ret_ok;
    logic          spurious;
    logic          fifo_full;
    logic          fifo_ovf;
    res_entry_t    push_entry;
    res_entry_t    head;

    // Every issued op must already own a FIFO slot, since the FU cannot stall its output.
    assign occ         = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign credit_ok   = (occ < (CW+1)'(DEPTH));
    assign arg_rdy     = ~rst & ~fu_busy & credit_ok;
    assign fu_up_valid = arg_vld & arg_rdy;
    assign fu_a        = arg_a;
    assign fu_b        = arg_b;

    assign ret_ok     = fu_down_valid & (inflight != '0);
    assign spurious   = fu_down_valid & (inflight == '0);
    assign push_entry = '{err: fu_error, data: fu_res};

    f_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_ok),
        .push_data (push_entry),
        .pop       (res_vld & res_rdy),
        .pop_data  (head),
        .cnt       (fifo_cnt),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );

    assign res_vld  = (fifo_cnt != '0);
    assign res_data = head.data;
    assign res_err  = head.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (fu_up_valid && !ret_ok) begin
                inflight <= inflight + CW'(1);
            end else if (!fu_up_valid && ret_ok) begin
                inflight <= inflight - CW'(1);
            end
            if (spurious || fifo_ovf) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_f_issue_seq.sv
// tb/tb_f_issue_seq.sv - directed bench for f_issue_seq with a behavioural FU stub
module tb_f_issue_seq;
    import f_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          arg_vld;
    logic          arg_rdy;
    logic [63:0]   arg_a;
    logic [63:0]   arg_b;
    logic          fu_up_valid;
    logic [63:0]   fu_a;
    logic [63:0]   fu_b;
    logic [63:0]   fu_res;
    logic          fu_down_valid;
    logic          fu_busy;
    logic          fu_error;
    logic          res_vld;
    logic          res_rdy;
    logic [63:0]   res_data;
    logic          res_err;
    logic [CW-1:0] inflight;
    logic          proto_err;

    always #5 clk = ~clk;

    f_issue_seq #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .arg_vld       (arg_vld),
        .arg_rdy       (arg_rdy),
        .arg_a         (arg_a),
        .arg_b         (arg_b),
        .fu_up_valid   (fu_up_valid),
        .fu_a          (fu_a),
        .fu_b          (fu_b),
        .fu_res        (fu_res),
        .fu_down_valid (fu_down_valid),
        .fu_busy       (fu_busy),
        .fu_error      (fu_error),
        .res_vld       (res_vld),
        .res_rdy       (res_rdy),
        .res_data      (res_data),
        .res_err       (res_err),
        .inflight      (inflight),
        .proto_err     (proto_err)
    );

    // FU stub: result lat cycles after issue, busy bsy cycles after issue.
    int          lat = 3;
    int          bsy = 0;
    int          busy_cnt;
    logic        spur = 1'b0;
    logic        sv [1:8];
    logic [63:0] sd [1:8];
    logic        se [1:8];

    assign fu_down_valid = sv[1] | spur;
    assign fu_res        = sd[1];
    assign fu_error      = se[1];
    assign fu_busy       = (busy_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= 8; k++) begin
                sv[k] <= 1'b0;
                sd[k] <= '0;
                se[k] <= 1'b0;
            end
            busy_cnt <= 0;
        end else begin
            for (int k = 1; k < 8; k++) begin
                sv[k] <= sv[k+1];
                sd[k] <= sd[k+1];
                se[k] <= se[k+1];
            end
            sv[8] <= 1'b0;
            if (fu_up_valid) begin
                sv[lat]  <= 1'b1;
                sd[lat]  <= fu_a ^ fu_b;
                se[lat]  <= (fu_a == 64'd0);
                busy_cnt <= bsy;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          idx = 0;
    int          nops = 0;
    int          max_inf;
    int          busy_viol;
    int          first_vld;
    logic        took;
    logic [63:0] a_tab [16];
    logic [63:0] b_tab [16];
    logic [64:0] exp_q [$];
    logic [64:0] popped [$];
    int          issue_cyc [$];

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive from the operand table, record handshakes, score pops.
    task automatic cyc();
        logic [64:0] e;
        arg_vld = (idx < nops);
        arg_a   = a_tab[idx % 16];
        arg_b   = b_tab[idx % 16];
        #1;
        took = arg_vld & arg_rdy;
        if (took) begin
            exp_q.push_back({(arg_a == 64'd0), arg_a ^ arg_b});
            issue_cyc.push_back(cyc_n);
            idx++;
        end
        if (fu_up_valid && fu_busy) busy_viol++;
        if (int'(inflight) > max_inf) max_inf = int'(inflight);
        if (res_vld && first_vld < 0) first_vld = cyc_n;
        if (res_vld && res_rdy) begin
            popped.push_back({res_err, res_data});
            chk("pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_order", {res_err, res_data}, e);
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((idx < nops || exp_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_done", (idx >= nops) && (exp_q.size() == 0), 1'b1);
    endtask

    task automatic start(input int n);
        idx = 0;
        nops = n;
        exp_q.delete();
        popped.delete();
        issue_cyc.delete();
        first_vld = -1;
        max_inf = 0;
        busy_viol = 0;
    endtask

    initial begin
        rst = 1'b1;
        arg_vld = 1'b0;
        arg_a = '0;
        arg_b = '0;
        res_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arg_vld = 1'b1;
        #1;
        chk("rdy_in_rst", arg_rdy, 1'b0);
        chk("upv_in_rst", fu_up_valid, 1'b0);
        arg_vld = 1'b0;
        chk("rst_inflight", inflight, 0);
        chk("rst_res_vld", res_vld, 1'b0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_proto", proto_err, 1'b0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", arg_rdy, 1'b1);
        @(posedge clk);
        #1;

        // Streaming
        lat = 3; bsy = 0; res_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_tab[i] = 64'(i);
            b_tab[i] = 64'hFF;
        end
        start(8);
        drain(100);
        chk("stream_count", popped.size(), 8);
        chk("stream_first_lat", first_vld - issue_cyc[0], 4);
        chk("stream_first_data", popped[0], {1'b1, 64'hFF});
        chk("stream_last_data", popped[7], {1'b0, 64'hF8});
        chk("stream_max_inflight", max_inf <= 3, 1'b1);
        chk("stream_proto", proto_err, 1'b0);

        // Backpressure
        res_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_tab[i] = 64'(i + 16);
            b_tab[i] = 64'hF0;
        end
        start(10);
        repeat (10) cyc();
        chk("bp_accepted", idx, 4);
        chk("bp_rdy_held", arg_rdy, 1'b0);
        chk("bp_res_vld", res_vld, 1'b1);
        res_rdy = 1'b1;
        cyc();
        chk("bp_rdy_during_pop", took, 1'b0);
        res_rdy = 1'b0;
        #1;
        chk("bp_rdy_after_pop", arg_rdy, 1'b1);
        chk("bp_first", popped[0], {1'b0, 64'hE0});
        res_rdy = 1'b1;
        drain(200);
        chk("bp_count", popped.size(), 10);
        chk("bp_last", popped[9], {1'b0, 64'hE9});

        // Busy FU
        bsy = 2;
        for (int i = 0; i < 4; i++) begin
            a_tab[i] = 64'(i + 1);
            b_tab[i] = 64'd5;
        end
        start(4);
        drain(100);
        chk("busy_count", popped.size(), 4);
        chk("busy_viol", busy_viol, 0);
        chk("busy_gap1", issue_cyc[1] - issue_cyc[0], 3);
        chk("busy_gap3", issue_cyc[3] - issue_cyc[2], 3);
        bsy = 0;

        // Error propagation
        a_tab[0] = 64'd0; b_tab[0] = 64'd5;
        a_tab[1] = 64'd3; b_tab[1] = 64'd5;
        start(2);
        drain(50);
        chk("err_flag_set", popped[0], {1'b1, 64'd5});
        chk("err_flag_clear", popped[1], {1'b0, 64'd6});

        // Spurious result
        start(0);
        res_rdy = 1'b0;
        chk("spur_pre_inflight", inflight, 0);
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        chk("spur_proto", proto_err, 1'b1);
        chk("spur_no_vld", res_vld, 1'b0);
        repeat (3) cyc();
        chk("spur_sticky", proto_err, 1'b1);
        chk("spur_still_empty", res_vld, 1'b0);
        chk("spur_inflight", inflight, 0);

        // Reset mid-flight: 3 issued, 2 of them buffered
        for (int i = 0; i < 3; i++) begin
            a_tab[i] = 64'(i + 7);
            b_tab[i] = 64'd1;
        end
        start(3);
        repeat (5) cyc();
        chk("mid_inflight_pre", inflight, 1);
        chk("mid_vld_pre", res_vld, 1'b1);
        rst = 1'b1;
        nops = idx;
        cyc();
        exp_q.delete();
        chk("mid_inflight", inflight, 0);
        chk("mid_res_vld", res_vld, 1'b0);
        chk("mid_proto", proto_err, 1'b0);
        chk("mid_res_data", res_data, 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rdy", arg_rdy, 1'b1);
        repeat (6) cyc();
        chk("mid_no_late", proto_err, 1'b0);
        chk("mid_still_empty", res_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
